// File: rtl/fetch_stage.sv
// Instruction fetch stage: keeps the pc, reads a combinational instruction
// memory and presents one registered fetch packet to decode. Redirects from
// execute flush the in-flight packet; misaligned targets produce one fault
// packet and park the stage until an aligned redirect or reset.
//
// Handshake: a packet transfers on a cycle where out_valid && out_ready.
// While out_valid is high and out_ready is low the packet, pc and state are
// frozen. out_valid does not depend combinationally on out_ready.
module fetch_stage #(
  parameter int          DEPTH    = 4096,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int         AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_instr,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_instr,
  output logic [31:0]   out_pc,
  output logic          out_fault,
  output logic          fsm_state
);

  // Instruction placed in the fault packet so it decodes harmlessly (addi x0,x0,0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        valid_nxt;
  logic [31:0] instr_nxt;
  logic [31:0] opc_nxt;
  logic        fault_nxt;
  logic        stall;

  // The memory only sees the low address bits; pc keeps all 32.
  assign imem_addr = pc[AW-1:0];
  assign fsm_state = state;
  assign stall     = out_valid && !out_ready;

  // Next-state and next-packet selection: redirect, then stall, then fetch.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    valid_nxt = out_valid;
    instr_nxt = out_instr;
    opc_nxt   = out_pc;
    fault_nxt = out_fault;
    if (redirect_valid) begin
      if (redirect_pc[1:0] == 2'b00) begin
        // Flush whatever is presented; the target is fetched next cycle.
        pc_nxt    = redirect_pc;
        valid_nxt = 1'b0;
        state_nxt = RUN;
      end else begin
        // Report the bad target as a packet; pc is left where it was.
        state_nxt = FAULT;
        valid_nxt = 1'b1;
        fault_nxt = 1'b1;
        opc_nxt   = redirect_pc;
        instr_nxt = NOP_INSTR;
      end
    end else if (!stall) begin
      case (state)
        RUN: begin
          valid_nxt = 1'b1;
          instr_nxt = imem_instr;
          opc_nxt   = pc;
          fault_nxt = 1'b0;
          pc_nxt    = pc + 32'd4;
        end
        FAULT: begin
          // Fault packet consumed (or already gone): stay idle.
          valid_nxt = 1'b0;
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  // State, pc and output packet registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      out_instr <= 32'd0;
      out_pc    <= 32'd0;
      out_fault <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      out_valid <= valid_nxt;
      out_instr <= instr_nxt;
      out_pc    <= opc_nxt;
      out_fault <= fault_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed sequences for reset, stall, redirect, fault
// and pc wrap, followed by a random back-pressure run. Every accepted packet
// is compared against the expected queue filled as stimulus is driven.
module tb_fetch_stage;

  localparam int          DEPTH    = 4096;
  localparam int          AW       = 12;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic          clk;
  logic          rst;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_instr;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic          out_fault;
  logic          fsm_state;

  int errors = 0;
  int checks = 0;

  logic [64:0] exp_q[$];

  fetch_stage #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_fault     (out_fault),
    .fsm_state     (fsm_state)
  );

  // Memory model: the word at byte address a holds a + 0x100.
  assign imem_instr = 32'(imem_addr) + 32'h100;

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a & 32'(DEPTH - 1)) + 32'h100;
  endfunction

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock, then apply inputs for the new cycle.
  task automatic cyc(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rst            = r;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  task automatic push_pkt(input logic f, input logic [31:0] pc, input logic [31:0] instr);
    exp_q.push_back({f, pc, instr});
  endtask

  task automatic push_run(input logic [31:0] pc);
    push_pkt(1'b0, pc, mem_word(pc));
  endtask

  // Scoreboard: compare every accepted packet with the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_extra_pkt", {out_fault, out_pc, out_instr}, 65'd0);
      end else begin
        chk("sb_pkt", {out_fault, out_pc, out_instr}, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] npc;
    logic        rdy;
    rst            = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;

    // Reset state.
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    chk("rst_valid", 65'(out_valid), 65'd0);
    chk("rst_instr", 65'(out_instr), 65'd0);
    chk("rst_pc", 65'(out_pc), 65'd0);
    chk("rst_fault", 65'(out_fault), 65'd0);
    chk("rst_state", 65'(fsm_state), 65'd0);
    chk("rst_addr", 65'(imem_addr), 65'(RESET_PC[AW-1:0]));

    // Release: one empty cycle, then 0, 4, 8.
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    chk("rel_gap", 65'(out_valid), 65'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0); push_run(32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0); push_run(32'h4);

    // Stall three cycles on the pc=8 packet.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'd0);
      @(negedge clk);
      chk("stall_pc", 65'(out_pc), 65'h8);
      chk("stall_valid", 65'(out_valid), 65'd1);
      chk("stall_addr", 65'(imem_addr), 65'hC);
    end
    cyc(1'b0, 1'b1, 1'b0, 32'd0); push_run(32'h8);
    cyc(1'b0, 1'b1, 1'b0, 32'd0); push_run(32'hC);

    // Redirect to 0x40 while stalled on the 0x10 packet.
    cyc(1'b0, 1'b0, 1'b1, 32'h40);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    chk("redir_gap", 65'(out_valid), 65'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0); push_run(32'h40);
    @(negedge clk);
    chk("redir_pc", 65'(out_pc), 65'h40);
    cyc(1'b0, 1'b1, 1'b0, 32'd0); push_run(32'h44);

    // Misaligned redirect to 0x42 while the 0x48 packet is stalled.
    cyc(1'b0, 1'b0, 1'b1, 32'h42);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'd0);
      @(negedge clk);
      chk("fault_pkt", {out_valid, out_fault, out_pc, out_instr[30:0]}, {1'b1, 1'b1, 32'h42, 31'h13});
      chk("fault_state", 65'(fsm_state), 65'd1);
    end
    cyc(1'b0, 1'b1, 1'b0, 32'd0); push_pkt(1'b1, 32'h42, 32'h13);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'd0);
      @(negedge clk);
      chk("fault_idle", 65'(out_valid), 65'd0);
      chk("fault_pc_hold", 65'(imem_addr), 65'h4C);
    end

    // Aligned redirect to 0x80 resumes fetch.
    cyc(1'b0, 1'b1, 1'b1, 32'h80);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    chk("resume_gap", 65'(out_valid), 65'd0);
    chk("resume_state", 65'(fsm_state), 65'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0); push_run(32'h80);
    cyc(1'b0, 1'b1, 1'b0, 32'd0); push_run(32'h84);

    // Packet accepted in the redirect cycle is consumed; the next one is flushed.
    cyc(1'b0, 1'b1, 1'b1, 32'h100); push_run(32'h88);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    chk("accept_redir_gap", 65'(out_valid), 65'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0); push_run(32'h100);

    // pc wrap at the top of the address space.
    cyc(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8); push_run(32'h104);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    chk("wrap_addr0", 65'(imem_addr), 65'hFF8);
    cyc(1'b0, 1'b1, 1'b0, 32'd0); push_run(32'hFFFF_FFF8);
    @(negedge clk);
    chk("wrap_addr1", 65'(imem_addr), 65'hFFC);
    cyc(1'b0, 1'b1, 1'b0, 32'd0); push_run(32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_addr2", 65'(imem_addr), 65'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0); push_run(32'h0);

    // Reset during FAULT with a redirect pending.
    cyc(1'b0, 1'b0, 1'b1, 32'h3);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    chk("fault2_pc", 65'(out_pc), 65'h3);
    cyc(1'b1, 1'b0, 1'b1, 32'h80);
    cyc(1'b1, 1'b0, 1'b1, 32'h80);
    @(negedge clk);
    chk("rst2_valid", 65'(out_valid), 65'd0);
    chk("rst2_state", 65'(fsm_state), 65'd0);
    chk("rst2_fault", 65'(out_fault), 65'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    chk("rel2_gap", 65'(out_valid), 65'd0);
    chk("rel2_addr", 65'(imem_addr), 65'(RESET_PC[AW-1:0]));
    cyc(1'b0, 1'b1, 1'b0, 32'd0); push_run(RESET_PC);
    cyc(1'b0, 1'b1, 1'b0, 32'd0); push_run(RESET_PC + 32'd4);

    // Random back-pressure on a straight-line stream.
    npc = RESET_PC + 32'd8;
    for (int i = 0; i < 40; i++) begin
      rdy = 1'($urandom_range(0, 1));
      cyc(1'b0, rdy, 1'b0, 32'd0);
      if (rdy) begin
        push_run(npc);
        npc = npc + 32'd4;
      end
      @(negedge clk);
      chk("rand_valid", 65'(out_valid), 65'd1);
    end

    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    chk("sb_drained", 65'(exp_q.size()), 65'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
